dac_spi_responder: RTL and testbench

- Synthesizable SPI responder that models the four-channel 12-bit serial DAC driven by dac_adapter; it sits on the far side of SPI_SCK/SPI_MOSI/DAC_CS/DAC_CLR and drives SPI_MISO.
- It decodes 32-bit command frames, maintains per-channel input and DAC registers, and echoes the previous frame on SPI_MISO.
- It is used as a loopback target in simulation and on-board checks of the DAC master.

---
 rtl/dac_spi_responder_pkg.sv | 42 ++++
 rtl/dac_spi_responder_sync_edge.sv | 32 +++
 rtl/dac_spi_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_dac_spi_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_responder_pkg.sv
// Shared constants for the DAC SPI responder: command codes,
// frame field positions, channel select helper and FSM encoding.
package dac_spi_responder_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 12;

  localparam logic [3:0] CMD_WRITE         = 4'h0;
  localparam logic [3:0] CMD_UPDATE        = 4'h1;
  localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WRITE_UPD     = 4'h3;
  localparam logic [3:0] CMD_PDOWN         = 4'h4;
  localparam logic [3:0] CMD_NOP           = 4'hF;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  // One-hot channel mask for an address; unknown
  // addresses select nothing.
  function automatic logic [NUM_CH-1:0] chan_sel(
    input logic [3:0] addr
  );
    logic [NUM_CH-1:0] m;
    m = '0;
    if (addr == ADDR_ALL)
      m = '1;
    else if (addr < 4'(NUM_CH))
      m[addr[1:0]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/dac_spi_responder_sync_edge.sv
// Per-signal synchronizer with rise/fall pulses.
// Ports: CLOCK, RESET, i_d (async in), o_q (synced), o_rise, o_fall.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/dac_spi_responder.sv
// SPI responder modelling a 4-channel 12-bit serial DAC.
// Ports: CLOCK/RESET, SPI_SCK/SPI_MOSI/DAC_CS/DAC_CLR in, SPI_MISO echo,
// FRAME_VALID/FRAME_ERROR pulses, CMD/ADDR/DATA, DAC_OUT, POWER_DOWN,
// BIT_COUNT.
module dac_spi_responder
  import dac_spi_responder_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  input  logic        DAC_CS,
  input  logic        DAC_CLR,
  output logic        FRAME_VALID,
  output logic        FRAME_ERROR,
  output logic [3:0]  CMD,
  output logic [3:0]  ADDR,
  output logic [11:0] DATA,
  output logic [47:0] DAC_OUT,
  output logic [3:0]  POWER_DOWN,
  output logic [5:0]  BIT_COUNT
);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_clr_q, w_clr_rise, w_clr_fall;

  // Idle levels at reset: CS and CLR high so no
  // spurious frame start or clear after reset.
  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .i_d   (SPI_SCK),
    .o_q   (w_sck_q),
    .o_rise(w_sck_rise),
    .o_fall(w_sck_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_mosi (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .i_d   (SPI_MOSI),
    .o_q   (w_mosi_q),
    .o_rise(w_mosi_rise),
    .o_fall(w_mosi_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .i_d   (DAC_CS),
    .o_q   (w_cs_q),
    .o_rise(w_cs_rise),
    .o_fall(w_cs_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_clr (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .i_d   (DAC_CLR),
    .o_q   (w_clr_q),
    .o_rise(w_clr_rise),
    .o_fall(w_clr_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sck_q, w_mosi_rise, w_mosi_fall,
                      w_cs_q, w_clr_rise, w_clr_fall};

  logic [1:0]  r_state;
  logic [31:0] r_rx;
  logic [31:0] r_echo;
  logic [31:0] r_shift;
  logic        r_miso;
  logic [5:0]  r_bit_count;
  logic        r_valid;
  logic        r_error;
  logic [3:0]  r_cmd;
  logic [3:0]  r_addr;
  logic [11:0] r_data;

  logic [NUM_CH-1:0][CH_W-1:0] r_in;
  logic [NUM_CH-1:0][CH_W-1:0] r_dac;
  logic [NUM_CH-1:0]           r_pd;

  logic [3:0]  w_rx_cmd;
  logic [3:0]  w_rx_addr;
  logic [11:0] w_rx_data;
  logic [3:0]  w_sel;
  logic        w_exec;
  logic        w_exec_ok;

  assign w_rx_cmd  = r_rx[CMD_MSB:CMD_LSB];
  assign w_rx_addr = r_rx[ADDR_MSB:ADDR_LSB];
  assign w_rx_data = r_rx[DATA_MSB:DATA_LSB];
  assign w_sel     = chan_sel(w_rx_addr);
  assign w_exec    = (r_state == ST_EXEC);
  assign w_exec_ok = w_exec &&
                     (r_bit_count == 6'(FRAME_BITS));

  // Frame FSM, receive shifter and echo path.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_rx        <= '0;
      r_echo      <= '0;
      r_shift     <= '0;
      r_miso      <= 1'b0;
      r_bit_count <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state     <= ST_SHIFT;
            r_bit_count <= '0;
            r_shift     <= r_echo;
            r_miso      <= r_echo[31];
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_state <= ST_EXEC;
          end else begin
            if (w_sck_rise) begin
              r_rx <= {r_rx[30:0], w_mosi_q};
              if (r_bit_count != 6'h3F)
                r_bit_count <= r_bit_count + 6'd1;
            end
            if (w_sck_fall) begin
              r_shift <= {r_shift[30:0], 1'b0};
              r_miso  <= r_shift[30];
            end
          end
        end
        ST_EXEC: begin
          r_state <= ST_IDLE;
          if (w_exec_ok) begin
            r_valid <= 1'b1;
            r_cmd   <= w_rx_cmd;
            r_addr  <= w_rx_addr;
            r_data  <= w_rx_data;
            r_echo  <= r_rx;
          end else begin
            r_error <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [NUM_CH-1:0][CH_W-1:0] w_in_nxt;
  logic [NUM_CH-1:0][CH_W-1:0] w_dac_nxt;
  logic [NUM_CH-1:0]           w_pd_nxt;

  // Command execution; a held clear overrides any
  // write landing in the same cycle.
  always_comb begin
    w_in_nxt  = r_in;
    w_dac_nxt = r_dac;
    w_pd_nxt  = r_pd;
    if (w_exec_ok) begin
      case (w_rx_cmd)
        CMD_WRITE: begin
          for (int ch = 0; ch < NUM_CH; ch++)
            if (w_sel[ch]) w_in_nxt[ch] = w_rx_data;
        end
        CMD_UPDATE: begin
          for (int ch = 0; ch < NUM_CH; ch++)
            if (w_sel[ch]) begin
              w_dac_nxt[ch] = r_in[ch];
              w_pd_nxt[ch]  = 1'b0;
            end
        end
        CMD_WRITE_UPD_ALL: begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_sel[ch]) w_in_nxt[ch] = w_rx_data;
            w_dac_nxt[ch] = w_in_nxt[ch];
          end
        end
        CMD_WRITE_UPD: begin
          for (int ch = 0; ch < NUM_CH; ch++)
            if (w_sel[ch]) begin
              w_in_nxt[ch]  = w_rx_data;
              w_dac_nxt[ch] = w_rx_data;
              w_pd_nxt[ch]  = 1'b0;
            end
        end
        CMD_PDOWN: begin
          for (int ch = 0; ch < NUM_CH; ch++)
            if (w_sel[ch]) w_pd_nxt[ch] = 1'b1;
        end
        default: ;
      endcase
    end
    if (!w_clr_q) begin
      w_in_nxt  = '0;
      w_dac_nxt = '0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_in  <= '0;
      r_dac <= '0;
      r_pd  <= '0;
    end else begin
      r_in  <= w_in_nxt;
      r_dac <= w_dac_nxt;
      r_pd  <= w_pd_nxt;
    end
  end

  assign SPI_MISO    = r_miso;
  assign FRAME_VALID = r_valid;
  assign FRAME_ERROR = r_error;
  assign CMD         = r_cmd;
  assign ADDR        = r_addr;
  assign DATA        = r_data;
  assign DAC_OUT     = r_dac;
  assign POWER_DOWN  = r_pd;
  assign BIT_COUNT   = r_bit_count;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Testbench for dac_spi_responder: frame table plus
// scoreboard of expected frame results.
module tb_dac_spi_responder;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        SPI_SCK;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic        DAC_CS;
  logic        DAC_CLR;
  logic        FRAME_VALID;
  logic        FRAME_ERROR;
  logic [3:0]  CMD;
  logic [3:0]  ADDR;
  logic [11:0] DATA;
  logic [47:0] DAC_OUT;
  logic [3:0]  POWER_DOWN;
  logic [5:0]  BIT_COUNT;

  dac_spi_responder dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .SPI_SCK    (SPI_SCK),
    .SPI_MOSI   (SPI_MOSI),
    .SPI_MISO   (SPI_MISO),
    .DAC_CS     (DAC_CS),
    .DAC_CLR    (DAC_CLR),
    .FRAME_VALID(FRAME_VALID),
    .FRAME_ERROR(FRAME_ERROR),
    .CMD        (CMD),
    .ADDR       (ADDR),
    .DATA       (DATA),
    .DAC_OUT    (DAC_OUT),
    .POWER_DOWN (POWER_DOWN),
    .BIT_COUNT  (BIT_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  localparam int HALF = 6;

  typedef struct {
    logic        is_valid;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [47:0] dac;
    logic [3:0]  pd;
    logic [5:0]  bc;
  } exp_t;

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [31:0] echo;
    exp_t        e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  function automatic vec_t mk(
    input logic [31:0] frame, input int nbits,
    input logic [31:0] echo, input logic v,
    input logic [3:0] c, input logic [3:0] a,
    input logic [11:0] d, input logic [47:0] dac,
    input logic [3:0] pd, input logic [5:0] bc);
    vec_t t;
    t.frame      = frame;
    t.nbits      = nbits;
    t.echo       = echo;
    t.e.is_valid = v;
    t.e.cmd      = c;
    t.e.addr     = a;
    t.e.data     = d;
    t.e.dac      = dac;
    t.e.pd       = pd;
    t.e.bc       = bc;
    return t;
  endfunction

  // Scoreboard: compare each frame result pulse.
  always @(negedge CLOCK) begin
    exp_t e;
    if (FRAME_VALID || FRAME_ERROR) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse",
            {62'd0, FRAME_VALID, FRAME_ERROR}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind",
            {62'd0, FRAME_VALID, FRAME_ERROR},
            e.is_valid ? 64'd2 : 64'd1);
        chk("cmd", {60'd0, CMD}, {60'd0, e.cmd});
        chk("addr", {60'd0, ADDR}, {60'd0, e.addr});
        chk("data", {52'd0, DATA}, {52'd0, e.data});
        chk("dac_out", {16'd0, DAC_OUT}, {16'd0, e.dac});
        chk("power_down", {60'd0, POWER_DOWN},
            {60'd0, e.pd});
        chk("bit_count", {58'd0, BIT_COUNT},
            {58'd0, e.bc});
      end
    end
  end

  task automatic shift_bits(input logic [31:0] tx,
                            input int n,
                            output logic [31:0] rx);
    rx = '0;
    DAC_CS = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = (i < 32) ? tx[31-i] : 1'b0;
      wait_clk(HALF);
      SPI_SCK = 1'b1;
      rx = {rx[30:0], SPI_MISO};
      wait_clk(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic end_frame();
    wait_clk(HALF);
    DAC_CS = 1'b1;
    wait_clk(4);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 50) begin
      wait_clk(1);
      k++;
    end
    chk("pending_results", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rx;
    q.push_back(v.e);
    shift_bits(v.frame, v.nbits, rx);
    end_frame();
    drain();
    chk("miso_echo", {32'd0, rx},
        {32'd0, v.echo >> (32 - v.nbits)});
  endtask

  initial begin
    RESET    = 1'b1;
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    DAC_CS   = 1'b1;
    DAC_CLR  = 1'b1;

    tbl.push_back(mk(32'h0030_ABC0, 32, 32'h0, 1,
      4'h3, 4'h0, 12'hABC, 48'h000_000_000_ABC, 4'h0, 32));
    tbl.push_back(mk(32'h000F_5550, 32, 32'h0030_ABC0, 1,
      4'h0, 4'hF, 12'h555, 48'h000_000_000_ABC, 4'h0, 32));
    tbl.push_back(mk(32'h001F_0000, 32, 32'h000F_5550, 1,
      4'h1, 4'hF, 12'h000, 48'h555_555_555_555, 4'h0, 32));
    tbl.push_back(mk(32'h0012_3450, 20, 32'h001F_0000, 0,
      4'h1, 4'hF, 12'h000, 48'h555_555_555_555, 4'h0, 20));
    tbl.push_back(mk(32'h0032_0010, 32, 32'h001F_0000, 1,
      4'h3, 4'h2, 12'h001, 48'h555_001_555_555, 4'h0, 32));
    tbl.push_back(mk(32'h0042_0000, 32, 32'h0032_0010, 1,
      4'h4, 4'h2, 12'h000, 48'h555_001_555_555, 4'h4, 32));
    tbl.push_back(mk(32'h0032_0020, 32, 32'h0042_0000, 1,
      4'h3, 4'h2, 12'h002, 48'h555_002_555_555, 4'h0, 32));
    tbl.push_back(mk(32'h0020_7770, 32, 32'h0032_0020, 1,
      4'h2, 4'h0, 12'h777, 48'h555_002_555_777, 4'h0, 32));
    tbl.push_back(mk(32'h0075_1110, 32, 32'h0020_7770, 1,
      4'h7, 4'h5, 12'h111, 48'h555_002_555_777, 4'h0, 32));
    tbl.push_back(mk(32'h0035_2220, 32, 32'h0075_1110, 1,
      4'h3, 4'h5, 12'h222, 48'h555_002_555_777, 4'h0, 32));
    tbl.push_back(mk(32'h0000_0000, 0, 32'h0035_2220, 0,
      4'h3, 4'h5, 12'h222, 48'h555_002_555_777, 4'h0, 0));
    tbl.push_back(mk(32'h0044_FFF0, 31, 32'h0035_2220, 0,
      4'h3, 4'h5, 12'h222, 48'h555_002_555_777, 4'h0, 31));
    tbl.push_back(mk(32'h00FF_0000, 32, 32'h0035_2220, 1,
      4'hF, 4'hF, 12'h000, 48'h555_002_555_777, 4'h0, 32));
    tbl.push_back(mk(32'h004F_0000, 32, 32'h00FF_0000, 1,
      4'h4, 4'hF, 12'h000, 48'h555_002_555_777, 4'hF, 32));
    tbl.push_back(mk(32'h0011_0000, 32, 32'h004F_0000, 1,
      4'h1, 4'h1, 12'h000, 48'h555_002_555_777, 4'hD, 32));

    wait_clk(5);
    RESET = 1'b0;
    wait_clk(5);

    chk("rst_miso", {63'd0, SPI_MISO}, 64'd0);
    chk("rst_valid", {63'd0, FRAME_VALID}, 64'd0);
    chk("rst_error", {63'd0, FRAME_ERROR}, 64'd0);
    chk("rst_cmd", {60'd0, CMD}, 64'd0);
    chk("rst_data", {52'd0, DATA}, 64'd0);
    chk("rst_dac", {16'd0, DAC_OUT}, 64'd0);
    chk("rst_pd", {60'd0, POWER_DOWN}, 64'd0);
    chk("rst_bc", {58'd0, BIT_COUNT}, 64'd0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Clear held across the EXEC of a write to B.
    DAC_CLR = 1'b0;
    wait_clk(6);
    run_vec(mk(32'h0031_FFF0, 32, 32'h0011_0000, 1,
      4'h3, 4'h1, 12'hFFF, 48'h0, 4'hD, 32));
    DAC_CLR = 1'b1;
    wait_clk(6);
    chk("clr_release_dac", {16'd0, DAC_OUT}, 64'd0);
    // Input registers were cleared too.
    run_vec(mk(32'h001F_0000, 32, 32'h0031_FFF0, 1,
      4'h1, 4'hF, 12'h000, 48'h0, 4'h0, 32));

    // Reset in the middle of a frame.
    begin
      logic [31:0] rx;
      shift_bits(32'h0012_3450, 16, rx);
      chk("mid_bc", {58'd0, BIT_COUNT}, 64'd16);
      RESET = 1'b1;
      wait_clk(2);
      chk("mrst_bc", {58'd0, BIT_COUNT}, 64'd0);
      chk("mrst_cmd", {60'd0, CMD}, 64'd0);
      chk("mrst_miso", {63'd0, SPI_MISO}, 64'd0);
      DAC_CS = 1'b1;
      wait_clk(3);
      RESET = 1'b0;
      wait_clk(6);
      chk("mrst_error", {63'd0, FRAME_ERROR}, 64'd0);
    end
    run_vec(mk(32'h0031_1230, 32, 32'h0, 1,
      4'h3, 4'h1, 12'h123, 48'h000_000_123_000, 4'h0, 32));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
